// File: rtl/nrzi_stuff_encoder_if.sv
// -----------------------------------------------------------------------------
// nrzi_stuff_encoder_if
// Bundles the serial-bit handshake and the encoded line outputs of
// nrzi_stuff_encoder.
//   data_valid_i  : producer -> encoder, data_i holds a valid logical bit
//   data_i        : producer -> encoder, logical (pre-stuff, pre-NRZI) bit
//   data_ready_o  : encoder -> producer, bit is accepted this cycle
//   data_o        : encoder -> line, NRZI-encoded line bit (registered)
//   out_valid_o   : encoder -> line, data_o updated by a data or stuff bit
//   stuffed_o     : encoder -> line, current data_o bit is a stuff bit
// Modports: master = bit producer / line consumer, slave = the encoder.
// -----------------------------------------------------------------------------
interface nrzi_stuff_encoder_if;
  logic data_valid_i;
  logic data_i;
  logic data_ready_o;
  logic data_o;
  logic out_valid_o;
  logic stuffed_o;

  modport master (
    output data_valid_i,
    output data_i,
    input  data_ready_o,
    input  data_o,
    input  out_valid_o,
    input  stuffed_o
  );

  modport slave (
    input  data_valid_i,
    input  data_i,
    output data_ready_o,
    output data_o,
    output out_valid_o,
    output stuffed_o
  );
endinterface

// File: rtl/nrzi_stuff_encoder.sv
// -----------------------------------------------------------------------------
// nrzi_stuff_encoder
// Serial TX line encoder: accepts logical bits over a valid/ready handshake,
// inserts a stuffed 0 after MAX_ONES consecutive logical ones (optional) and
// NRZI-encodes the resulting stream onto a registered line bit.
// Ports:
//   clk12_i  : bit clock
//   rst_i    : synchronous active-high reset
//   bit_en_i : bit-time strobe, state advances only when high
//   clear_i  : synchronous line clear (packet start / after EOP)
//   bus      : nrzi_stuff_encoder_if.slave (handshake + encoded outputs)
// -----------------------------------------------------------------------------
module nrzi_stuff_encoder #(
  parameter int INITIAL_VALUE      = 1,     // idle (J-equivalent) line level
  parameter bit ZERO_AS_TRANSITION = 1'b1,  // 1: a 0 toggles the line, 0: a 1 toggles
  parameter bit STUFF_ENABLE       = 1'b1,  // 1: insert stuff bits
  parameter int MAX_ONES           = 6,     // run length that triggers a stuff bit (1..15)
  localparam int CNT_W             = $clog2(MAX_ONES + 1)
) (
  input  logic                clk12_i,
  input  logic                rst_i,
  input  logic                bit_en_i,
  input  logic                clear_i,
  nrzi_stuff_encoder_if.slave bus
);

  localparam logic             INIT_LEVEL = INITIAL_VALUE[0];
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_ONES);

  typedef enum logic {
    ST_DATA  = 1'b0,  // accepting logical bits
    ST_STUFF = 1'b1   // emitting a stuffed 0, input stalled
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_data;
  logic             r_out_valid;
  logic             r_stuffed;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_next_data;
  logic             w_next_out_valid;
  logic             w_next_stuffed;

  logic             w_ready;
  logic             w_transfer;
  logic             w_stuff_slot;
  logic             w_bit;
  logic             w_toggle;
  logic             w_encoded;

  // Ready depends only on state and clear, never on the bit strobe, so the
  // producer can present the next bit while bit_en_i is low.
  assign w_ready      = !clear_i && (r_state == ST_DATA);
  assign w_transfer   = bit_en_i && bus.data_valid_i && w_ready;
  assign w_stuff_slot = bit_en_i && (r_state == ST_STUFF);

  // A stuff slot always encodes a logical 0.
  assign w_bit     = w_stuff_slot ? 1'b0 : bus.data_i;
  assign w_toggle  = ZERO_AS_TRANSITION ? !w_bit : w_bit;
  assign w_encoded = r_data ^ w_toggle;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path leaves a variable unassigned, which would infer a latch.
    w_next_state     = r_state;
    w_next_cnt       = r_cnt;
    w_next_data      = r_data;
    w_next_out_valid = 1'b0;
    w_next_stuffed   = 1'b0;

    if (clear_i) begin
      // Clear wins over any bit-time, discarding a pending stuff bit.
      w_next_state = ST_DATA;
      w_next_cnt   = '0;
      w_next_data  = INIT_LEVEL;
    end else if (w_stuff_slot) begin
      w_next_state     = ST_DATA;
      w_next_cnt       = '0;
      w_next_data      = w_encoded;
      w_next_out_valid = 1'b1;
      w_next_stuffed   = 1'b1;
    end else if (w_transfer) begin
      w_next_data      = w_encoded;
      w_next_out_valid = 1'b1;
      if (bus.data_i) begin
        // Saturate instead of wrapping; only reachable without stuffing.
        if (r_cnt != MAX_CNT) begin
          w_next_cnt = w_cnt_inc;
        end
        if (STUFF_ENABLE && (w_cnt_inc == MAX_CNT)) begin
          w_next_state = ST_STUFF;
        end
      end else begin
        w_next_cnt = '0;
      end
    end
  end

  always_ff @(posedge clk12_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      r_state     <= ST_DATA;
      r_cnt       <= '0;
      r_data      <= INIT_LEVEL;
      r_out_valid <= 1'b0;
      r_stuffed   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_data      <= w_next_data;
      r_out_valid <= w_next_out_valid;
      r_stuffed   <= w_next_stuffed;
    end
  end

  assign bus.data_ready_o = w_ready;
  assign bus.data_o       = r_data;
  assign bus.out_valid_o  = r_out_valid;
  assign bus.stuffed_o    = r_stuffed;

endmodule

// File: tb/tb_nrzi_stuff_encoder.sv
// -----------------------------------------------------------------------------
// tb_nrzi_stuff_encoder
// Four encoder instances with different parameter sets share one stimulus
// stream. A behavioural model (line level, run length, pending-stuff flag)
// predicts every instance each cycle; a vector table and a few hand-written
// sequences pin down the key scenarios with explicit expected values.
// -----------------------------------------------------------------------------
module tb_nrzi_stuff_encoder;

  localparam int N_DUT = 4;

  typedef struct {
    int init;
    bit zat;
    bit se;
    int max;
  } cfg_t;

  typedef struct {
    bit line;
    int ones;
    bit pending;
    bit valid;
    bit stuffed;
  } mdl_t;

  typedef struct {
    bit en;
    bit clr;
    bit vld;
    bit d;
    bit exp_ready;
    bit exp_data;
    bit exp_valid;
    bit exp_stuffed;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic bit_en;
  logic clear;
  logic vld;
  logic din;

  int checks   = 0;
  int failures = 0;

  cfg_t cfg [N_DUT];
  mdl_t m   [N_DUT];
  vec_t tbl [$];

  logic [N_DUT-1:0] w_ready;
  logic [N_DUT-1:0] w_data;
  logic [N_DUT-1:0] w_valid;
  logic [N_DUT-1:0] w_stuffed;
  logic [N_DUT-1:0] pre_ready;

  nrzi_stuff_encoder_if if_a ();
  nrzi_stuff_encoder_if if_b ();
  nrzi_stuff_encoder_if if_c ();
  nrzi_stuff_encoder_if if_d ();

  assign if_a.data_valid_i = vld;  assign if_a.data_i = din;
  assign if_b.data_valid_i = vld;  assign if_b.data_i = din;
  assign if_c.data_valid_i = vld;  assign if_c.data_i = din;
  assign if_d.data_valid_i = vld;  assign if_d.data_i = din;

  assign w_ready   = {if_d.data_ready_o, if_c.data_ready_o, if_b.data_ready_o, if_a.data_ready_o};
  assign w_data    = {if_d.data_o,       if_c.data_o,       if_b.data_o,       if_a.data_o};
  assign w_valid   = {if_d.out_valid_o,  if_c.out_valid_o,  if_b.out_valid_o,  if_a.out_valid_o};
  assign w_stuffed = {if_d.stuffed_o,    if_c.stuffed_o,    if_b.stuffed_o,    if_a.stuffed_o};

  // A: defaults (INIT=1, ZAT=1, stuffing, 6 ones)
  nrzi_stuff_encoder dut_a (
    .clk12_i(clk), .rst_i(rst), .bit_en_i(bit_en), .clear_i(clear), .bus(if_a.slave)
  );

  // B: ones toggle, stuffing disabled (counter saturates)
  nrzi_stuff_encoder #(
    .INITIAL_VALUE(1), .ZERO_AS_TRANSITION(1'b0), .STUFF_ENABLE(1'b0), .MAX_ONES(6)
  ) dut_b (
    .clk12_i(clk), .rst_i(rst), .bit_en_i(bit_en), .clear_i(clear), .bus(if_b.slave)
  );

  // C: smallest legal run length, idle level 0
  nrzi_stuff_encoder #(
    .INITIAL_VALUE(0), .ZERO_AS_TRANSITION(1'b1), .STUFF_ENABLE(1'b1), .MAX_ONES(1)
  ) dut_c (
    .clk12_i(clk), .rst_i(rst), .bit_en_i(bit_en), .clear_i(clear), .bus(if_c.slave)
  );

  // D: largest legal run length, ones toggle, stuffing on
  nrzi_stuff_encoder #(
    .INITIAL_VALUE(1), .ZERO_AS_TRANSITION(1'b0), .STUFF_ENABLE(1'b1), .MAX_ONES(15)
  ) dut_d (
    .clk12_i(clk), .rst_i(rst), .bit_en_i(bit_en), .clear_i(clear), .bus(if_d.slave)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic mdl_t model_reset(input cfg_t c);
    mdl_t s;
    s.line    = c.init[0];
    s.ones    = 0;
    s.pending = 1'b0;
    s.valid   = 1'b0;
    s.stuffed = 1'b0;
    return s;
  endfunction

  // One bit-time of the line encoder, stated in terms of the line level,
  // the length of the current run of ones and whether a stuff bit is owed.
  function automatic mdl_t model_step(input cfg_t c, input mdl_t s,
                                      input bit r, input bit clr,
                                      input bit en, input bit v, input bit d);
    mdl_t n;
    bit   accept;
    n         = s;
    n.valid   = 1'b0;
    n.stuffed = 1'b0;
    accept    = !clr && !s.pending && en && v;
    if (r || clr) begin
      n = model_reset(c);
    end else if (en && s.pending) begin
      if (c.zat) n.line = !s.line;  // stuff bit is a logical 0
      n.ones    = 0;
      n.pending = 1'b0;
      n.valid   = 1'b1;
      n.stuffed = 1'b1;
    end else if (accept) begin
      if ((d == 1'b0) == c.zat) n.line = !s.line;
      n.valid = 1'b1;
      if (d) begin
        n.ones = (s.ones < c.max) ? s.ones + 1 : c.max;
        if (c.se && n.ones == c.max) n.pending = 1'b1;
      end else begin
        n.ones = 0;
      end
    end
    return n;
  endfunction

  // Apply one cycle of stimulus to all instances and compare them to the model.
  task automatic cycle(input bit r, input bit c, input bit e, input bit v, input bit d);
    rst    = r;
    clear  = c;
    bit_en = e;
    vld    = v;
    din    = d;
    #1;
    for (int k = 0; k < N_DUT; k++) begin
      pre_ready[k] = w_ready[k];
      check($sformatf("model_ready[%0d]", k), w_ready[k], !c && !m[k].pending);
      m[k] = model_step(cfg[k], m[k], r, c, e, v, d);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N_DUT; k++) begin
      check($sformatf("model_data[%0d]", k),    w_data[k],    m[k].line);
      check($sformatf("model_valid[%0d]", k),   w_valid[k],   m[k].valid);
      check($sformatf("model_stuffed[%0d]", k), w_stuffed[k], m[k].stuffed);
    end
  endtask

  task automatic add(input bit en, input bit clr, input bit v, input bit d,
                     input bit er, input bit ed, input bit ev, input bit es);
    vec_t t;
    t.en = en; t.clr = clr; t.vld = v; t.d = d;
    t.exp_ready = er; t.exp_data = ed; t.exp_valid = ev; t.exp_stuffed = es;
    tbl.push_back(t);
  endtask

  initial begin
    cfg[0] = '{init: 1, zat: 1'b1, se: 1'b1, max: 6};
    cfg[1] = '{init: 1, zat: 1'b0, se: 1'b0, max: 6};
    cfg[2] = '{init: 0, zat: 1'b1, se: 1'b1, max: 1};
    cfg[3] = '{init: 1, zat: 1'b0, se: 1'b1, max: 15};
    for (int k = 0; k < N_DUT; k++) m[k] = model_reset(cfg[k]);

    // Expected behaviour of instance A, row by row.
    // Eight zeros: line toggles every bit starting from idle 1.
    for (int i = 0; i < 8; i++) add(1, 0, 1, 0, 1, bit'(i % 2), 1, 0);
    // Seven ones: six hold, stuff slot stalls input and toggles, 7th holds.
    for (int i = 0; i < 6; i++) add(1, 0, 1, 1, 1, 1, 1, 0);
    add(1, 0, 1, 1, 0, 0, 1, 1);
    add(1, 0, 1, 1, 1, 0, 1, 0);
    add(1, 0, 1, 0, 1, 1, 1, 0);
    // Five ones, three-cycle valid gap, then two ones.
    for (int i = 0; i < 5; i++) add(1, 0, 1, 1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 1, 1, 0, 0);
    add(1, 0, 1, 1, 1, 1, 1, 0);
    add(1, 0, 1, 1, 0, 0, 1, 1);
    add(1, 0, 1, 1, 1, 0, 1, 0);
    // Two zeros, six ones, clear in the stuff cycle: stuff discarded.
    add(1, 0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 1, 0, 1, 0, 0);
    add(1, 0, 1, 1, 1, 1, 1, 0);
    // Stuff bit emitted while data_valid is low.
    add(1, 0, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 1, 1, 1, 0, 1, 0);
    add(1, 0, 0, 1, 0, 1, 1, 1);
    add(1, 0, 0, 1, 1, 1, 0, 0);
    // bit_en every 4th cycle, valid bits 1,0,1.
    add(1, 0, 1, 1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 1, 1, 0, 0);
    add(1, 0, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0, 1, 0);
    // Clear acts even without a bit strobe.
    add(0, 1, 1, 1, 0, 1, 0, 0);

    rst = 1'b1; clear = 1'b0; bit_en = 1'b0; vld = 1'b0; din = 1'b0;
    @(posedge clk);
    #1;

    // Reset state of instance A.
    cycle(1, 0, 0, 0, 0);
    check("reset_data",    w_data[0],    1'b1);
    check("reset_valid",   w_valid[0],   1'b0);
    check("reset_stuffed", w_stuffed[0], 1'b0);
    #1;
    check("reset_ready",   w_ready[0],   1'b1);

    foreach (tbl[i]) begin
      cycle(0, tbl[i].clr, tbl[i].en, tbl[i].vld, tbl[i].d);
      check($sformatf("vec%0d_ready", i),   pre_ready[0], tbl[i].exp_ready);
      check($sformatf("vec%0d_data", i),    w_data[0],    tbl[i].exp_data);
      check($sformatf("vec%0d_valid", i),   w_valid[0],   tbl[i].exp_valid);
      check($sformatf("vec%0d_stuffed", i), w_stuffed[0], tbl[i].exp_stuffed);
    end

    // Instance B: ten ones after a clear toggle every bit, never stuff.
    cycle(0, 1, 1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 1, 1);
      check($sformatf("b_ones%0d_ready", i),   pre_ready[1], 1'b1);
      check($sformatf("b_ones%0d_data", i),    w_data[1],    bit'(i % 2));
      check($sformatf("b_ones%0d_stuffed", i), w_stuffed[1], 1'b0);
    end

    // Instance A: reset while a stuff bit is pending discards it.
    cycle(0, 1, 1, 1, 1);
    cycle(0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, 1);
    cycle(1, 0, 1, 1, 1);
    check("rst_pending_data",    w_data[0],    1'b1);
    check("rst_pending_valid",   w_valid[0],   1'b0);
    check("rst_pending_stuffed", w_stuffed[0], 1'b0);
    cycle(0, 0, 1, 1, 1);
    check("rst_pending_ready",   pre_ready[0], 1'b1);
    check("rst_pending_hold",    w_data[0],    1'b1);

    // Randomised traffic biased towards long runs of ones.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 9) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
